// File: rtl/csi_tx_pkg.sv
// ---------------------------------------------------------------------------
// csi_tx_pkg
// Shared definitions for the CSI-2 D-PHY transmit lane controllers.
//   - clk_lane_state_e : clock-lane sequencer states
//   - HS_ZERO/HS_TOGGLE: serializer bytes (bit0 leaves the OSERDES first)
//   - LP_11/LP_01/LP_00: LP line levels packed as {P, N}
//   - timer_load       : converts a T_* duration into a down-counter preset
// ---------------------------------------------------------------------------
package csi_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_HS_RQST = 4'd1,
    ST_PREPARE = 4'd2,
    ST_ZERO    = 4'd3,
    ST_PRE     = 4'd4,
    ST_RUN     = 4'd5,
    ST_POST    = 4'd6,
    ST_TRAIL   = 4'd7,
    ST_EXIT    = 4'd8
  } clk_lane_state_e;

  localparam logic [7:0] HS_ZERO   = 8'h00;
  localparam logic [7:0] HS_TOGGLE = 8'h55;

  // LP levels as {P, N}
  localparam logic [1:0] LP_11 = 2'b11;
  localparam logic [1:0] LP_01 = 2'b01;
  localparam logic [1:0] LP_00 = 2'b00;

  // A state lasting T cycles is preset to T-1 and left when the counter is
  // zero; a duration of 0 is treated as a single cycle.
  function automatic int unsigned timer_load(input int unsigned t);
    if (t == 32'd0) begin
      return 32'd0;
    end else begin
      return t - 32'd1;
    end
  endfunction

endpackage

// File: rtl/csi_tx_lane_timer.sv
// ---------------------------------------------------------------------------
// csi_tx_lane_timer
// Down-counter used to time D-PHY lane states.
// Ports:
//   clk        in  1      byte clock
//   rst        in  1      asynchronous reset, active-high (counter -> 0)
//   load       in  1      preset the counter with load_value this cycle
//   load_value in  CNT_W  preset value
//   zero       out 1      counter currently at zero
// The counter holds at zero once it gets there.
// ---------------------------------------------------------------------------
module csi_tx_lane_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // counter register: preset on load, otherwise count down to zero and hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != {CNT_W{1'b0}}) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/csi_tx_clk_lane.sv
// ---------------------------------------------------------------------------
// csi_tx_clk_lane
// MIPI CSI-2 D-PHY transmit clock-lane controller (byte-clock domain).
// Walks LP-11 -> LP-01 -> LP-00 -> HS-0 -> HS clock and back again.
// Ports:
//   CLK       in  1  byte clock (bit clock / 4)
//   RST       in  1  asynchronous reset, active-high
//   HS_REQ    in  1  level request for a running HS clock
//   HS_READY  out 1  HS clock running, data lanes may enter HS
//   BUSY      out 1  high in every state except IDLE
//   LP_P      out 1  LP driver, P line
//   LP_N      out 1  LP driver, N line
//   HS_OE     out 1  HS driver enable (LP driver tri-stated when 1)
//   HS_DATA   out 8  byte to the clock-lane OSERDES, bit0 first
// All outputs are registered and decoded from the next state, so they
// change in the same cycle the state is entered.
// ---------------------------------------------------------------------------
module csi_tx_clk_lane
  import csi_tx_pkg::*;
#(
  parameter int unsigned T_LPX         = 4,
  parameter int unsigned T_CLK_PREPARE = 3,
  parameter int unsigned T_CLK_ZERO    = 20,
  parameter int unsigned T_CLK_PRE     = 2,
  parameter int unsigned T_CLK_POST    = 8,
  parameter int unsigned T_CLK_TRAIL   = 4,
  parameter int unsigned T_HS_EXIT     = 6,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       HS_REQ,
  output logic       HS_READY,
  output logic       BUSY,
  output logic       LP_P,
  output logic       LP_N,
  output logic       HS_OE,
  output logic [7:0] HS_DATA
);

  localparam logic [CNT_W-1:0] LD_LPX     = CNT_W'(timer_load(T_LPX));
  localparam logic [CNT_W-1:0] LD_PREPARE = CNT_W'(timer_load(T_CLK_PREPARE));
  localparam logic [CNT_W-1:0] LD_ZERO    = CNT_W'(timer_load(T_CLK_ZERO));
  localparam logic [CNT_W-1:0] LD_PRE     = CNT_W'(timer_load(T_CLK_PRE));
  localparam logic [CNT_W-1:0] LD_POST    = CNT_W'(timer_load(T_CLK_POST));
  localparam logic [CNT_W-1:0] LD_TRAIL   = CNT_W'(timer_load(T_CLK_TRAIL));
  localparam logic [CNT_W-1:0] LD_EXIT    = CNT_W'(timer_load(T_HS_EXIT));

  clk_lane_state_e  state_r;
  clk_lane_state_e  next_state_s;
  logic             timer_load_s;
  logic [CNT_W-1:0] timer_value_s;
  logic             timer_zero_s;

  logic [1:0]       lp_s;
  logic             hs_oe_s;
  logic [7:0]       hs_data_s;
  logic             hs_ready_s;
  logic             busy_s;

  logic [1:0]       lp_r;
  logic             hs_oe_r;
  logic [7:0]       hs_data_r;
  logic             hs_ready_r;
  logic             busy_r;

  csi_tx_lane_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (CLK),
    .rst        (RST),
    .load       (timer_load_s),
    .load_value (timer_value_s),
    .zero       (timer_zero_s)
  );

  // next-state logic plus timer preset on entry to a timed state
  always_comb begin
    next_state_s  = state_r;
    timer_load_s  = 1'b0;
    timer_value_s = {CNT_W{1'b0}};

    case (state_r)
      ST_IDLE:    if (HS_REQ)       next_state_s = ST_HS_RQST; else next_state_s = ST_IDLE;
      ST_HS_RQST: if (timer_zero_s) next_state_s = ST_PREPARE; else next_state_s = ST_HS_RQST;
      ST_PREPARE: if (timer_zero_s) next_state_s = ST_ZERO;    else next_state_s = ST_PREPARE;
      ST_ZERO:    if (timer_zero_s) next_state_s = ST_PRE;     else next_state_s = ST_ZERO;
      ST_PRE:     if (timer_zero_s) next_state_s = ST_RUN;     else next_state_s = ST_PRE;
      // the request is only looked at again once the clock is running
      ST_RUN:     if (!HS_REQ)      next_state_s = ST_POST;    else next_state_s = ST_RUN;
      ST_POST:    if (timer_zero_s) next_state_s = ST_TRAIL;   else next_state_s = ST_POST;
      ST_TRAIL:   if (timer_zero_s) next_state_s = ST_EXIT;    else next_state_s = ST_TRAIL;
      ST_EXIT:    if (timer_zero_s) next_state_s = ST_IDLE;    else next_state_s = ST_EXIT;
      default:    next_state_s = ST_IDLE;
    endcase

    if (next_state_s != state_r) begin
      timer_load_s = 1'b1;
      case (next_state_s)
        ST_HS_RQST: timer_value_s = LD_LPX;
        ST_PREPARE: timer_value_s = LD_PREPARE;
        ST_ZERO:    timer_value_s = LD_ZERO;
        ST_PRE:     timer_value_s = LD_PRE;
        ST_POST:    timer_value_s = LD_POST;
        ST_TRAIL:   timer_value_s = LD_TRAIL;
        ST_EXIT:    timer_value_s = LD_EXIT;
        default:    timer_value_s = {CNT_W{1'b0}};
      endcase
    end else begin
      timer_load_s  = 1'b0;
      timer_value_s = {CNT_W{1'b0}};
    end
  end

  // output decode from the next state
  always_comb begin
    lp_s       = LP_11;
    hs_oe_s    = 1'b0;
    hs_data_s  = HS_ZERO;
    hs_ready_s = 1'b0;
    busy_s     = 1'b1;

    case (next_state_s)
      ST_IDLE:    begin lp_s = LP_11; busy_s = 1'b0; end
      ST_HS_RQST: begin lp_s = LP_01; end
      ST_PREPARE: begin lp_s = LP_00; end
      ST_ZERO:    begin lp_s = LP_00; hs_oe_s = 1'b1; end
      ST_PRE:     begin lp_s = LP_00; hs_oe_s = 1'b1; hs_data_s = HS_TOGGLE; end
      ST_RUN:     begin lp_s = LP_00; hs_oe_s = 1'b1; hs_data_s = HS_TOGGLE; hs_ready_s = 1'b1; end
      ST_POST:    begin lp_s = LP_00; hs_oe_s = 1'b1; hs_data_s = HS_TOGGLE; end
      ST_TRAIL:   begin lp_s = LP_00; hs_oe_s = 1'b1; end
      ST_EXIT:    begin lp_s = LP_11; end
      default:    begin lp_s = LP_11; busy_s = 1'b0; end
    endcase
  end

  // state and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      lp_r       <= LP_11;
      hs_oe_r    <= 1'b0;
      hs_data_r  <= HS_ZERO;
      hs_ready_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      lp_r       <= lp_s;
      hs_oe_r    <= hs_oe_s;
      hs_data_r  <= hs_data_s;
      hs_ready_r <= hs_ready_s;
      busy_r     <= busy_s;
    end
  end

  assign LP_P     = lp_r[1];
  assign LP_N     = lp_r[0];
  assign HS_OE    = hs_oe_r;
  assign HS_DATA  = hs_data_r;
  assign HS_READY = hs_ready_r;
  assign BUSY     = busy_r;

endmodule

// File: tb/tb_csi_tx_clk_lane.sv
// ---------------------------------------------------------------------------
// tb_csi_tx_clk_lane
// Directed bench for the clock-lane controller. Expected per-cycle output
// vectors {LP_P, LP_N, HS_OE, HS_DATA, HS_READY, BUSY} are queued as the
// stimulus is applied and popped one per clock, 1 time unit after the edge.
// dut0 uses default timing, dut1 has every T_* set to 0.
// ---------------------------------------------------------------------------
module tb_csi_tx_clk_lane;

  localparam logic [12:0] E_IDLE  = {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
  localparam logic [12:0] E_RQST  = {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
  localparam logic [12:0] E_PREP  = {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
  localparam logic [12:0] E_ZERO  = {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
  localparam logic [12:0] E_PRE   = {1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1};
  localparam logic [12:0] E_RUN   = {1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1};
  localparam logic [12:0] E_POST  = {1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1};
  localparam logic [12:0] E_TRAIL = {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
  localparam logic [12:0] E_EXIT  = {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       hs_req0 = 1'b0;
  logic       hs_req1 = 1'b0;

  logic       hs_ready0, busy0, lp_p0, lp_n0, hs_oe0;
  logic [7:0] hs_data0;
  logic       hs_ready1, busy1, lp_p1, lp_n1, hs_oe1;
  logic [7:0] hs_data1;

  typedef struct {
    logic [12:0] v;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   sel        = 1'b0;

  always #5 CLK = ~CLK;

  csi_tx_clk_lane dut0 (
    .CLK      (CLK),
    .RST      (RST),
    .HS_REQ   (hs_req0),
    .HS_READY (hs_ready0),
    .BUSY     (busy0),
    .LP_P     (lp_p0),
    .LP_N     (lp_n0),
    .HS_OE    (hs_oe0),
    .HS_DATA  (hs_data0)
  );

  csi_tx_clk_lane #(
    .T_LPX         (0),
    .T_CLK_PREPARE (0),
    .T_CLK_ZERO    (0),
    .T_CLK_PRE     (0),
    .T_CLK_POST    (0),
    .T_CLK_TRAIL   (0),
    .T_HS_EXIT     (0)
  ) dut1 (
    .CLK      (CLK),
    .RST      (RST),
    .HS_REQ   (hs_req1),
    .HS_READY (hs_ready1),
    .BUSY     (busy1),
    .LP_P     (lp_p1),
    .LP_N     (lp_n1),
    .HS_OE    (hs_oe1),
    .HS_DATA  (hs_data1)
  );

  task automatic push(input logic [12:0] v, input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.v   = v;
      e.tag = tag;
      sb_q.push_back(e);
    end
  endtask

  task automatic check();
    exp_t        e;
    logic [12:0] obs;
    obs = sel ? {lp_p1, lp_n1, hs_oe1, hs_data1, hs_ready1, busy1}
              : {lp_p0, lp_n0, hs_oe0, hs_data0, hs_ready0, busy0};
    if (sb_q.size() == 0) begin
      mismatched++;
      $error("FAIL sb_empty: observed %h required <queued entry>", obs);
    end else begin
      e = sb_q.pop_front();
      compared++;
      assert (obs === e.v) else begin
        mismatched++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    check();
  endtask

  task automatic drain();
    while (sb_q.size() > 0) step();
  endtask

  task automatic push_startup(input string pfx);
    push(E_RQST, {pfx, "_lp01"}, 4);
    push(E_PREP, {pfx, "_lp00"}, 3);
    push(E_ZERO, {pfx, "_hs0"}, 20);
    push(E_PRE,  {pfx, "_pre"}, 2);
  endtask

  task automatic push_shutdown(input string pfx);
    push(E_POST,  {pfx, "_post"}, 8);
    push(E_TRAIL, {pfx, "_trail"}, 4);
    push(E_EXIT,  {pfx, "_exit"}, 6);
  endtask

  initial begin
    // async reset before any clock edge
    #1 RST = 1'b1;
    #2;
    push(E_IDLE, "reset_async", 1);
    check();
    push(E_IDLE, "reset_held", 2);
    drain();
    RST = 1'b0;

    // 1: request after idle, full startup into RUN
    push(E_IDLE, "t1_idle", 9);
    drain();
    hs_req0 = 1'b1;
    push_startup("t1");
    push(E_RUN, "t1_run", 50);
    drain();

    // 2: request drops, full shutdown
    hs_req0 = 1'b0;
    push_shutdown("t2");
    push(E_IDLE, "t2_idle", 3);
    drain();

    // 3: one-cycle request pulse, committed startup
    hs_req0 = 1'b1;
    push(E_RQST, "t3_lp01", 1);
    drain();
    hs_req0 = 1'b0;
    push(E_RQST, "t3_lp01", 3);
    push(E_PREP, "t3_lp00", 3);
    push(E_ZERO, "t3_hs0", 20);
    push(E_PRE,  "t3_pre", 2);
    push(E_RUN,  "t3_run1", 1);
    push_shutdown("t3");
    push(E_IDLE, "t3_idle", 2);
    drain();

    // 4: request during TRAIL ignored until IDLE
    hs_req0 = 1'b1;
    push_startup("t4");
    push(E_RUN, "t4_run", 1);
    drain();
    hs_req0 = 1'b0;
    push(E_POST,  "t4_post", 8);
    push(E_TRAIL, "t4_trail", 2);
    drain();
    hs_req0 = 1'b1;
    push(E_TRAIL, "t4_trail_ign", 2);
    push(E_EXIT,  "t4_exit_ign", 6);
    push(E_IDLE,  "t4_idle1", 1);
    push(E_RQST,  "t4_rerqst", 4);
    push(E_PREP,  "t4_lp00", 3);
    push(E_ZERO,  "t4_hs0", 5);
    drain();

    // 5: reset in the middle of HS-0, then clean restart
    RST = 1'b1;
    #1;
    push(E_IDLE, "t5_async", 1);
    check();
    hs_req0 = 1'b0;
    push(E_IDLE, "t5_held", 2);
    drain();
    RST = 1'b0;
    push(E_IDLE, "t5_idle", 9);
    drain();
    hs_req0 = 1'b1;
    push_startup("t5");
    push(E_RUN, "t5_run", 3);
    drain();
    hs_req0 = 1'b0;
    push_shutdown("t5");
    push(E_IDLE, "t5_idle_end", 2);
    drain();

    // 6: all timings zero on dut1
    sel = 1'b1;
    push(E_IDLE, "t6_idle", 2);
    drain();
    hs_req1 = 1'b1;
    push(E_RQST, "t6_lp01", 1);
    push(E_PREP, "t6_lp00", 1);
    push(E_ZERO, "t6_hs0", 1);
    push(E_PRE,  "t6_pre", 1);
    push(E_RUN,  "t6_run", 3);
    drain();
    hs_req1 = 1'b0;
    push(E_POST,  "t6_post", 1);
    push(E_TRAIL, "t6_trail", 1);
    push(E_EXIT,  "t6_exit", 1);
    push(E_IDLE,  "t6_idle_end", 2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
